// File: rtl/grid_readout.sv
// Serial readout of a solved grid: snapshots one-hot tile values on request and
// streams them out as binary digits, one tile per valid/ready beat.
module grid_readout #(
  parameter int GRID_ORD = 3
) (
  input  logic                                                       clock,
  input  logic                                                       reset,
  input  logic                                                       grid_done,
  input  logic                                                       grid_success,
  input  logic [GRID_ORD*GRID_ORD*GRID_ORD*GRID_ORD*GRID_ORD*GRID_ORD-1:0] grid_values,
  input  logic                                                       rq,
  output logic                                                       rq_nack,
  output logic                                                       busy,
  output logic                                                       out_valid,
  input  logic                                                       out_ready,
  output logic [$clog2(GRID_ORD*GRID_ORD*GRID_ORD*GRID_ORD)-1:0]     out_index,
  output logic [$clog2(GRID_ORD*GRID_ORD+1)-1:0]                     out_digit,
  output logic                                                       out_last,
  output logic                                                       out_malformed
);

  localparam int GRID_LEN  = GRID_ORD * GRID_ORD;
  localparam int GRID_AREA = GRID_LEN * GRID_LEN;
  localparam int DIGIT_W   = $clog2(GRID_LEN + 1);
  localparam int IDX_W     = $clog2(GRID_AREA);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(GRID_AREA - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                          r_state, w_state_d;
  logic [GRID_AREA*GRID_LEN-1:0]   r_snap;
  logic                            w_capture;
  logic                            r_nack, w_nack_d;
  logic                            r_busy, w_busy_d;
  logic                            r_valid, w_valid_d;
  logic [IDX_W-1:0]                r_index, w_index_d;
  logic [DIGIT_W-1:0]              r_digit, w_digit_d;
  logic                            r_last, w_last_d;
  logic                            r_malformed, w_malformed_d;

  logic [IDX_W-1:0]                w_next_idx;
  logic [IDX_W-1:0]                w_rd_idx;
  logic [GRID_LEN-1:0]             w_next_tile;
  logic [DIGIT_W:0]                w_dec_first;
  logic [DIGIT_W:0]                w_dec_next;

  // Returns {malformed, digit}; digit is the lowest set bit plus one, 0 if empty.
  function automatic logic [DIGIT_W:0] decode(input logic [GRID_LEN-1:0] v);
    logic [DIGIT_W-1:0] digit;
    logic               multi;
    logic               seen;
    digit = '0;
    multi = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < GRID_LEN; k++) begin
      if (v[k]) begin
        if (seen) multi = 1'b1;
        else      digit = DIGIT_W'(k + 1);
        seen = 1'b1;
      end
    end
    return {multi, digit};
  endfunction

  assign w_next_idx  = r_index + 1'b1;
  // Keep the part-select in range on the final beat, where the result is unused.
  assign w_rd_idx    = r_last ? '0 : w_next_idx;
  assign w_next_tile = r_snap[int'(w_rd_idx)*GRID_LEN +: GRID_LEN];
  assign w_dec_first = decode(grid_values[GRID_LEN-1:0]);
  assign w_dec_next  = decode(w_next_tile);

  always_comb begin
    w_state_d     = r_state;
    w_capture     = 1'b0;
    w_nack_d      = 1'b0;
    w_busy_d      = r_busy;
    w_valid_d     = r_valid;
    w_index_d     = r_index;
    w_digit_d     = r_digit;
    w_last_d      = r_last;
    w_malformed_d = r_malformed;
    unique case (r_state)
      StIdle: begin
        if (rq) begin
          if (grid_done && grid_success) begin
            w_capture     = 1'b1;
            w_state_d     = StStream;
            w_busy_d      = 1'b1;
            w_valid_d     = 1'b1;
            w_index_d     = '0;
            w_digit_d     = w_dec_first[DIGIT_W-1:0];
            w_malformed_d = w_dec_first[DIGIT_W];
            w_last_d      = (LastIdx == '0);
          end else begin
            w_nack_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (r_valid && out_ready) begin
          if (r_last) begin
            w_state_d     = StIdle;
            w_busy_d      = 1'b0;
            w_valid_d     = 1'b0;
            w_index_d     = '0;
            w_digit_d     = '0;
            w_last_d      = 1'b0;
            w_malformed_d = 1'b0;
          end else begin
            w_index_d     = w_next_idx;
            w_digit_d     = w_dec_next[DIGIT_W-1:0];
            w_malformed_d = w_dec_next[DIGIT_W];
            w_last_d      = (w_next_idx == LastIdx);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_nack      <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_index     <= '0;
      r_digit     <= '0;
      r_last      <= 1'b0;
      r_malformed <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_nack      <= w_nack_d;
      r_busy      <= w_busy_d;
      r_valid     <= w_valid_d;
      r_index     <= w_index_d;
      r_digit     <= w_digit_d;
      r_last      <= w_last_d;
      r_malformed <= w_malformed_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_capture) r_snap <= grid_values;
  end

  assign rq_nack       = r_nack;
  assign busy          = r_busy;
  assign out_valid     = r_valid;
  assign out_index     = r_index;
  assign out_digit     = r_digit;
  assign out_last      = r_last;
  assign out_malformed = r_malformed;

endmodule

// File: doc/grid_readout.md
Name: grid_readout

Overview:
- Downstream of the sudoku grid solver; provides the serial solution-readout interface the solver lacks.
- After the solver reports done with success, a request snapshots all tile values.
  - Input values are one-hot, row-major.
  - The block streams them out one tile per beat over a valid/ready handshake, as binary digits.
- Also reports malformed one-hot values and rejects requests made when no solution exists.

Parameters:
- GRID_ORD, 3, grid order; the block size is GRID_ORD x GRID_ORD.
- GRID_LEN, GRID_ORD*GRID_ORD, derived (localparam): digits per row/col/block and one-hot value width.
- GRID_AREA, GRID_LEN*GRID_LEN, derived (localparam): tile count.
- DIGIT_W, $clog2(GRID_LEN+1), derived (localparam): binary digit width; 0 encodes an empty tile.
- IDX_W, $clog2(GRID_AREA), derived (localparam): tile index width.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Clears all state immediately when low.
- grid_done  input  1  solver has finished (success or failure).
- grid_success  input  1  solver found a solution. Only meaningful while grid_done=1.
- grid_values  input  GRID_AREA*GRID_LEN  one-hot tile values, row-major. Tile i occupies bits [i*GRID_LEN +: GRID_LEN].
- rq  input  1  readout request, level-sampled each cycle.
- rq_nack  output  1  one-cycle pulse: request rejected.
- busy  output  1  snapshot held and streaming in progress.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  IDX_W  row-major tile index of the beat.
- out_digit  output  DIGIT_W  onehot-index+1, or 0 if the tile is empty.
- out_last  output  1  beat is tile GRID_AREA-1.
- out_malformed  output  1  tile had more than one bit set.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: out_valid, busy, rq_nack, out_index, out_digit, out_last, out_malformed.
  - Snapshot contents are don't-care.
- States: IDLE, STREAM. All outputs are registered.
- IDLE:
  - rq=1 with grid_done=1 and grid_success=1:
    - Capture grid_values into the snapshot register.
    - Go to STREAM.
    - Next cycle: busy=1, out_valid=1, out_index=0, with decoded outputs for tile 0.
  - rq=1 with grid_done=0, or with grid_done=1 and grid_success=0:
    - rq_nack=1 for exactly the next cycle; stay in IDLE.
    - A held rq re-evaluates every cycle, so nack pulses repeat while rq stays high and the condition persists.
  - rq=0: no action.
- STREAM:
  - While out_valid=1 and out_ready=0, hold out_index, out_digit, out_last and out_malformed stable.
  - Beat accepted (out_valid & out_ready) with out_index < GRID_AREA-1:
    - out_index increments.
    - Next tile's decode is presented the following cycle.
    - out_valid stays 1, with no bubble.
  - Beat accepted with out_last=1: next cycle out_valid=0, busy=0, state IDLE.
  - rq is ignored during STREAM: no nack, no re-snapshot.
  - Changes on grid_values or grid_done do not affect the stream; only the snapshot is used.
- Decode rules (combinational from the snapshot, then registered):
  - Zero bits set: digit=0, malformed=0.
  - Exactly bit k set: digit=k+1, malformed=0.
  - More than one bit set: digit = lowest set bit + 1, malformed=1.
- out_last = (out_index == GRID_AREA-1). out_index never wraps.
- Throughput: 1 beat/cycle with out_ready held high, giving GRID_AREA beats in GRID_AREA cycles after the first valid.
- A request in the cycle after the final accept (IDLE, conditions met) starts a fresh snapshot with no extra idle cycle required.
- Reset asserted mid-stream: abort immediately. After release the block is in IDLE; no partial beat is replayed.

Test Plan:
- Solved 9x9 grid, tile0=9'b000000100, tile80=9'b100000000, out_ready=1, pulse rq:
  - out_valid rises one cycle after rq.
  - 81 consecutive beats with index 0..80.
  - Beat0 digit=3, beat80 digit=9, out_last only on beat 80.
  - busy falls the cycle after beat 80.
- rq with grid_done=0:
  - rq_nack=1 for one cycle, out_valid stays 0.
  - Repeat with grid_done=1, grid_success=0: same result.
- Backpressure:
  - Toggle out_ready 1,0,0,1 repeatedly.
  - Index/digit are held during the stall cycles.
  - All 81 beats arrive in order, no duplicates or drops.
- Snapshot isolation: after request acceptance, change grid_values for tile 5 from digit 4 to 7 → beat 5 still shows digit 4.
- Decode edges:
  - tile10=0 → digit 0, malformed 0.
  - tile11=9'b000010010 → digit 2, malformed 1.
  - tile12=9'b100000000 → digit 9.
- Reset mid-stream: at beat 40 drive reset low for 1 cycle → outputs 0 immediately. A new rq then streams from index 0.
